// File: rtl/ysyx_22041071_mem.sv
// Memory-access stage between EX and WB.
// ALU results pass straight through in one cycle. Loads and stores make a
// single aligned doubleword request on the data-memory port. Byte lanes are
// selected with a write mask. Load data is shifted down and then sign- or
// zero-extended. An access that crosses the doubleword is truncated to the
// lanes that lie inside that doubleword.
module ysyx_22041071_mem (
    input  logic        clk,
    input  logic        reset,
    // upstream (EX)
    input  logic        valid5,
    output logic        ready5,
    input  logic [63:0] PC5,
    input  logic [31:0] Ins4,
    input  logic        reg_w_en3,
    input  logic [4:0]  rdest2,
    input  logic [63:0] ALU_res,
    input  logic [63:0] st_data,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [2:0]  mem_size,
    // data memory
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_wmask,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [63:0] dmem_rdata,
    // downstream (WB)
    output logic        valid6,
    input  logic        ready6,
    output logic [63:0] PC6,
    output logic [31:0] Ins5,
    output logic        reg_w_en4,
    output logic [4:0]  rdest3,
    output logic [63:0] WB_data1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t      state_r;
    logic [63:0] pc_r;
    logic [31:0] ins_r;
    logic        wen_r;
    logic [4:0]  rd_r;
    logic [2:0]  off_r;
    logic [2:0]  size_r;
    logic        store_r;

    // Byte-lane mask for a store. Lanes shifted past bit 7 are dropped, so
    // an access that crosses the doubleword is truncated rather than split.
    function automatic logic [7:0] store_mask(input logic [2:0] size, input logic [2:0] off);
        logic [7:0] base;
        case (size[1:0])
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            2'b10:   base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    // Moves the store data into the byte lanes that the address selects.
    function automatic logic [63:0] store_data(input logic [63:0] data, input logic [2:0] off);
        return data << {off, 3'b000};
    endfunction

    // Moves the selected lanes down to bit 0, then extends to 64 bits.
    function automatic logic [63:0] load_format(input logic [63:0] raw,
                                                input logic [2:0]  off,
                                                input logic [2:0]  size);
        logic [63:0] sh;
        logic [63:0] res;
        sh = raw >> {off, 3'b000};
        case (size)
            3'b000:  res = {{56{sh[7]}},  sh[7:0]};
            3'b001:  res = {{48{sh[15]}}, sh[15:0]};
            3'b010:  res = {{32{sh[31]}}, sh[31:0]};
            3'b100:  res = {56'd0, sh[7:0]};
            3'b101:  res = {48'd0, sh[15:0]};
            3'b110:  res = {32'd0, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    // Upstream can hand over a new instruction only while nothing is in flight.
    assign ready5 = (state_r == IDLE);

    // Stage controller: sequences the access and owns every registered output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= IDLE;
            pc_r       <= 64'd0;
            ins_r      <= 32'd0;
            wen_r      <= 1'b0;
            rd_r       <= 5'd0;
            off_r      <= 3'd0;
            size_r     <= 3'd0;
            store_r    <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 64'd0;
            dmem_wdata <= 64'd0;
            dmem_wmask <= 8'd0;
            valid6     <= 1'b0;
            PC6        <= 64'd0;
            Ins5       <= 32'd0;
            reg_w_en4  <= 1'b0;
            rdest3     <= 5'd0;
            WB_data1   <= 64'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (valid5) begin
                        pc_r    <= PC5;
                        ins_r   <= Ins4;
                        wen_r   <= reg_w_en3;
                        rd_r    <= rdest2;
                        off_r   <= ALU_res[2:0];
                        size_r  <= mem_size;
                        store_r <= mem_w_en;
                        if (mem_r_en || mem_w_en) begin
                            // A load with the write flag also set is treated as a store.
                            state_r   <= REQ;
                            dmem_req  <= 1'b1;
                            dmem_we   <= mem_w_en;
                            dmem_addr <= {ALU_res[63:3], 3'b000};
                            if (mem_w_en) begin
                                dmem_wdata <= store_data(st_data, ALU_res[2:0]);
                                dmem_wmask <= store_mask(mem_size, ALU_res[2:0]);
                            end else begin
                                dmem_wdata <= 64'd0;
                                dmem_wmask <= 8'd0;
                            end
                        end else begin
                            state_r   <= OUT;
                            valid6    <= 1'b1;
                            WB_data1  <= ALU_res;
                            PC6       <= PC5;
                            Ins5      <= Ins4;
                            reg_w_en4 <= reg_w_en3;
                            rdest3    <= rdest2;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (store_r) begin
                            state_r   <= OUT;
                            valid6    <= 1'b1;
                            WB_data1  <= 64'd0;
                            PC6       <= pc_r;
                            Ins5      <= ins_r;
                            reg_w_en4 <= 1'b0;
                            rdest3    <= rd_r;
                        end else begin
                            state_r <= WAIT;
                        end
                    end else begin
                        state_r <= REQ;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        state_r   <= OUT;
                        valid6    <= 1'b1;
                        WB_data1  <= load_format(dmem_rdata, off_r, size_r);
                        PC6       <= pc_r;
                        Ins5      <= ins_r;
                        reg_w_en4 <= wen_r;
                        rdest3    <= rd_r;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                OUT: begin
                    if (ready6) begin
                        state_r <= IDLE;
                        valid6  <= 1'b0;
                    end else begin
                        state_r <= OUT;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    valid6   <= 1'b0;
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ysyx_22041071_mem.md
YSYX_22041071_MEM -- requirements
Module: ysyx_22041071_MEM

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-low (0 = reset), sampled on rising clk.
REQ-003 SHALL have upstream (EX) ports: valid5 in 1; ready5 out 1; PC5 in 64; Ins4 in 32; reg_w_en3 in 1; rdest2 in 5; ALU_res in 64 (result or address); st_data in 64; mem_r_en in 1; mem_w_en in 1; mem_size in 3 (funct3: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu).
REQ-004 SHALL have data-memory ports: dmem_req out 1; dmem_we out 1; dmem_addr out 64; dmem_wdata out 64; dmem_wmask out 8; dmem_gnt in 1; dmem_rvalid in 1; dmem_rdata in 64.
REQ-005 SHALL have downstream (WB) ports: valid6 out 1; ready6 in 1; PC6 out 64; Ins5 out 32; reg_w_en4 out 1; rdest3 out 5; WB_data1 out 64; all registered.

Function
REQ-006 SHALL implement FSM states IDLE, REQ, WAIT, OUT.
REQ-007 SHALL drive ready5 = 1 only in IDLE.
REQ-008 SHALL, in IDLE on valid5&ready5, latch PC5, Ins4, reg_w_en3, rdest2, ALU_res, st_data, mem_size, mem_r_en, mem_w_en.
REQ-009 SHALL, for a transfer with mem_r_en=mem_w_en=0, go IDLE->OUT, WB_data1 = ALU_res, valid6 high the next cycle (1-cycle latency).
REQ-010 SHALL, for mem_r_en or mem_w_en, go IDLE->REQ; if both set, treat as a store with reg_w_en4 forced 0.
REQ-011 SHALL, in REQ, hold dmem_req=1, dmem_we=latched mem_w_en, dmem_addr={addr[63:3],3'b000}, and wdata/wmask stable until dmem_gnt=1.
REQ-012 SHALL, on dmem_gnt in REQ: store -> OUT (WB_data1 = 0); load -> WAIT; dmem_req deasserts the cycle after gnt.
REQ-013 SHALL, in WAIT, ignore dmem_rdata until dmem_rvalid=1, then go OUT with WB_data1 = formatted load data.
REQ-014 SHALL form the store mask as b:8'h01, h:8'h03, w:8'h0F, d:8'hFF, shifted left by addr[2:0]; wdata = st_data shifted left by 8*addr[2:0].
REQ-015 SHALL extract load data as dmem_rdata >> 8*addr[2:0], truncated to size, sign-extended for b/h/w and zero-extended for bu/hu/wu/d.
REQ-016 SHALL truncate accesses crossing the 8-byte boundary to lanes within the doubleword; no trap, no second access.
REQ-017 SHALL hold valid6 and all downstream outputs stable in OUT until ready6=1, then return to IDLE the next cycle.
REQ-018 SHALL keep dmem_req=0 in IDLE, WAIT and OUT.
REQ-019 SHALL treat dmem_rvalid outside WAIT and dmem_gnt outside REQ as don't-care with no state change.

Reset
REQ-020 SHALL, while reset=0 at a clk edge, enter IDLE and clear valid6, dmem_req, dmem_we, reg_w_en4, rdest3, PC6, Ins5, WB_data1, dmem_addr, dmem_wdata, dmem_wmask to 0.
REQ-021 SHALL, on reset in REQ or WAIT, abandon the access; a late dmem_rvalid after reset is ignored.
REQ-022 SHALL drive ready5=1 from the first cycle after reset deassertion.

Verification
REQ-023 ALU op: ALU_res=64'h1234, reg_w_en3=1, rdest2=5, ready6=1 -> next cycle valid6=1, WB_data1=64'h1234, rdest3=5; ready5=1 again one cycle later.
REQ-024 lb: addr=64'h8000_0003, dmem_rdata=64'h0000_0000_8000_0000, gnt after 2 cycles, rvalid 3 cycles later -> WB_data1=64'hFFFF_FFFF_FFFF_FF80; lbu same -> 64'h80.
REQ-025 sh: addr=64'h8000_0006, st_data=64'hBEEF -> dmem_wmask=8'hC0, dmem_wdata[63:48]=16'hBEEF, dmem_we=1; after gnt valid6=1, WB_data1=0, reg_w_en4=0.
REQ-026 Backpressure: ready6=0 for 4 cycles in OUT -> valid6, WB_data1, PC6 unchanged, ready5=0, new valid5 not accepted until ready6=1.
REQ-027 Reset mid-load: reset=0 during WAIT, then rvalid=1 after release -> valid6 stays 0, state IDLE, ready5=1.
REQ-028 ld with dmem_gnt held 0 for 10 cycles -> dmem_req, dmem_addr stable throughout; completes normally after gnt.
